// File: rtl/pulse_period_meter_if.sv
// Interface bundling the enable/config/pulse inputs and the measurement outputs
// of the pulse period meter.
interface pulse_period_meter_if #(
   parameter int N = 8
);
   logic         ena;
   logic [N-1:0] ticks;
   logic         pulse_in;
   logic [N-1:0] period;
   logic         period_valid;
   logic         overflow;
   logic         locked;

   modport master (
      output ena, ticks, pulse_in,
      input  period, period_valid, overflow, locked
   );

   modport slave (
      input  ena, ticks, pulse_in,
      output period, period_valid, overflow, locked
   );
endinterface

// File: rtl/pulse_period_meter.sv
// Measures clk cycles between rising edges of pulse_in, flags intervals too long
// to count, and asserts lock after LOCK_COUNT consecutive periods equal to ticks.
//
// state      | meaning
// S_IDLE     | disabled or waiting for first edge; no period reported on that edge
// S_MEASURE  | counting cycles since the last edge
// S_OVERFLOW | interval exceeded 2**N-1; counter frozen until the next edge re-arms
module pulse_period_meter #(
   parameter int N          = 8,
   parameter int LOCK_COUNT = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   pulse_period_meter_if.slave  bus
);
   localparam int           MW      = $clog2(LOCK_COUNT + 1);
   localparam logic [MW-1:0] LC     = MW'(LOCK_COUNT);
   localparam logic [N-1:0]  CNT_MAX = {N{1'b1}};

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_MEASURE  = 2'd1,
      S_OVERFLOW = 2'd2
   } state_t;

   state_t          r_state, w_state_nxt;
   logic [N-1:0]    r_cnt, w_cnt_nxt;
   logic            r_prev;
   logic [N-1:0]    r_period, w_period_nxt;
   logic            r_period_valid, w_period_valid_nxt;
   logic            r_overflow, w_overflow_nxt;
   logic [MW-1:0]   r_match, w_match_nxt;
   logic            r_locked, w_locked_nxt;
   logic            w_edge;

   assign w_edge = bus.pulse_in & ~r_prev;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= S_IDLE;
         r_cnt          <= '0;
         r_prev         <= 1'b1;  // a level already high at reset release is not an edge
         r_period       <= '0;
         r_period_valid <= 1'b0;
         r_overflow     <= 1'b0;
         r_match        <= '0;
         r_locked       <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_cnt          <= w_cnt_nxt;
         r_prev         <= bus.pulse_in;
         r_period       <= w_period_nxt;
         r_period_valid <= w_period_valid_nxt;
         r_overflow     <= w_overflow_nxt;
         r_match        <= w_match_nxt;
         r_locked       <= w_locked_nxt;
      end
   end

   always_comb begin
      w_state_nxt        = r_state;
      w_cnt_nxt          = r_cnt;
      w_period_nxt       = r_period;
      w_period_valid_nxt = 1'b0;
      w_overflow_nxt     = 1'b0;
      w_match_nxt        = r_match;

      if (!bus.ena) begin
         w_state_nxt = S_IDLE;
         w_cnt_nxt   = '0;
         w_match_nxt = '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_edge) begin
                  w_state_nxt = S_MEASURE;
                  w_cnt_nxt   = N'(1);
               end
            end
            S_MEASURE: begin
               if (w_edge) begin
                  w_period_nxt       = r_cnt;
                  w_period_valid_nxt = 1'b1;
                  w_cnt_nxt          = N'(1);
                  if (r_cnt == bus.ticks)
                     w_match_nxt = (r_match == LC) ? LC : r_match + 1'b1;
                  else
                     w_match_nxt = '0;
               end else if (r_cnt != CNT_MAX) begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end else begin
                  w_state_nxt    = S_OVERFLOW;
                  w_overflow_nxt = 1'b1;
                  w_match_nxt    = '0;
               end
            end
            S_OVERFLOW: begin
               if (w_edge) begin
                  w_state_nxt = S_MEASURE;
                  w_cnt_nxt   = N'(1);
               end
            end
            default: begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
               w_match_nxt = '0;
            end
         endcase
      end

      w_locked_nxt = (w_match_nxt == LC);
   end

   assign bus.period       = r_period;
   assign bus.period_valid = r_period_valid;
   assign bus.overflow     = r_overflow;
   assign bus.locked       = r_locked;
endmodule
